vga_pixel_fetcher: RTL

Memory-side producer for the VGA data path. It streams 24-bit RGB pixels out of frame memory in raster order and serves them to the VGA data controller through that controller's read_en/Data interface. Internally it prefetches memory reads into a small first-word-fall-through FIFO so the display side never waits on memory latency. It sits between the memory controller read port and the VGAController Data input.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_pixel_fifo.sv | 60 ++++++
 rtl/vga_pixel_fetcher.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and defaults for the VGA pixel fetch path
package vga_pkg;

    localparam int H_RES_DEFAULT = 640;
    localparam int V_RES_DEFAULT = 480;
    localparam int PIXEL_W       = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/vga_pixel_fifo.sv
// rtl/vga_pixel_fifo.sv - first-word-fall-through prefetch FIFO with synchronous flush
module vga_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic                     Clock25,
    input  logic                     Reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO and a pop from an empty one are both ignored.
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr];

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge Clock25 or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array; no reset needed because level gates every read.
    always_ff @(posedge Clock25) begin
        if (do_push && !flush) mem_q[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vga_pixel_fetcher.sv
// rtl/vga_pixel_fetcher.sv - raster-order frame memory reader feeding the VGA data controller
module vga_pixel_fetcher
    import vga_pkg::*;
#(
    parameter int                H_RES        = H_RES_DEFAULT,
    parameter int                V_RES        = V_RES_DEFAULT,
    parameter int                ADDR_W       = 19,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                FIFO_DEPTH   = 16,
    parameter logic [23:0]       UNDERRUN_RGB = 24'hFF00FF
) (
    input  logic                          Clock25,
    input  logic                          Reset,
    input  logic                          frame_start,
    input  logic                          read_en,
    output logic [PIXEL_W-1:0]            Data,
    output logic                          mem_rd_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_rd_ack,
    input  logic                          mem_rd_valid,
    input  logic [PIXEL_W-1:0]            mem_rd_data,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int TOTAL = H_RES * V_RES;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    fetch_state_t      state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LW-1:0]     out_q, out_d;
    logic [LW-1:0]     disc_q, disc_d;
    logic [LW-1:0]     level_d;
    logic              req_q, req_d;
    logic              issue;
    logic              last_issue;
    logic              valid_live;
    logic              fifo_push, fifo_pop;
    logic              push_ok, pop_ok;
    logic              fifo_empty, fifo_full;
    pixel_t            fifo_head;

    assign issue      = req_q && mem_rd_ack;
    assign last_issue = issue && (idx_q == IDX_W'(TOTAL - 1));
    // Returns belonging to an abandoned frame are swallowed while discard is nonzero.
    assign valid_live = mem_rd_valid && (disc_q == '0);
    assign fifo_push  = !frame_start && valid_live;
    assign fifo_pop   = !frame_start && read_en;
    assign push_ok    = fifo_push && !fifo_full;
    assign pop_ok     = fifo_pop && !fifo_empty;

    assign mem_rd_req = req_q;
    assign mem_addr   = addr_q;
    assign Data       = fifo_empty ? UNDERRUN_RGB : fifo_head;

    vga_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .Clock25   (Clock25),
        .Reset     (Reset),
        .flush     (frame_start),
        .push      (fifo_push),
        .push_data (mem_rd_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Fetch FSM state register.
    always_ff @(posedge Clock25 or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Fetch FSM next state; frame_start restarts fetching from any state.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_FETCH: if (last_issue) state_d = ST_DRAIN;
                ST_DRAIN: if (out_q == '0) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Credit bookkeeping. On a restart every read still owed by memory, including
    // one accepted in the restart cycle itself, moves into the discard count.
    always_comb begin
        out_d  = out_q;
        disc_d = disc_q;
        if (frame_start) begin
            out_d  = '0;
            disc_d = LW'(int'(disc_q) + int'(out_q) + int'(issue) - int'(mem_rd_valid));
        end else begin
            if (mem_rd_valid && (disc_q != '0)) disc_d = disc_q - 1'b1;
            case ({issue, valid_live})
                2'b10:   out_d = out_q + 1'b1;
                2'b01:   out_d = out_q - 1'b1;
                default: out_d = out_q;
            endcase
        end
    end

    // Next FIFO occupancy and registered request. Once raised, the request holds
    // until accepted because nothing but an issue can grow the credit sum.
    always_comb begin
        level_d = fifo_level;
        if (frame_start)             level_d = '0;
        else if (push_ok && !pop_ok) level_d = fifo_level + 1'b1;
        else if (!push_ok && pop_ok) level_d = fifo_level - 1'b1;
        req_d = (state_d == ST_FETCH) &&
                ((int'(disc_d) + int'(level_d) + int'(out_d)) < FIFO_DEPTH);
    end

    // Address generation, credit registers and the sticky underrun flag.
    always_ff @(posedge Clock25 or negedge Reset) begin
        if (!Reset) begin
            idx_q    <= '0;
            addr_q   <= BASE_ADDR;
            out_q    <= '0;
            disc_q   <= '0;
            req_q    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            out_q  <= out_d;
            disc_q <= disc_d;
            req_q  <= req_d;
            if (frame_start) begin
                idx_q  <= '0;
                addr_q <= BASE_ADDR;
            end else if (issue) begin
                idx_q  <= idx_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
            if (!frame_start && read_en && fifo_empty) underrun <= 1'b1;
        end
    end

    // Crediting must keep a live return from ever landing on a full FIFO.
    assert property (@(posedge Clock25) disable iff (!Reset) fifo_push |-> !fifo_full);

endmodule
